// File: rtl/seq_div_unit_pkg.sv
// seq_div_unit_pkg: state encodings and iteration count shared by the divider and the hazard unit
//   DIV_CYCLES : iterations of one divide (one quotient bit per cycle)
//   divState_t : DIV_IDLE / DIV_CALC / DIV_DONE
package seq_div_unit_pkg;
  localparam int DIV_CYCLES = 32;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;
endpackage

// File: rtl/seq_div_unit_div_step.sv
// seq_div_unit_div_step: one combinational restoring-division iteration
//   rem, quo  : current partial remainder and dividend/quotient shift register
//   divisor   : divisor magnitude
//   nextRem   : partial remainder after this iteration
//   nextQuo   : shift register after this iteration, new quotient bit in bit 0
module seq_div_unit_div_step
  import seq_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextRem,
  output logic [WIDTH-1:0] nextQuo
);
  logic [WIDTH:0] shifted;
  logic           fits;
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    fits    = shifted >= {1'b0, divisor};
    // rem stays below divisor, so a successful subtraction always fits in WIDTH bits
    nextRem = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    nextQuo = {quo[WIDTH-2:0], fits};
  end
endmodule

// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle radix-2 restoring divider with start/busy/done handshake
//   clk, rst            : clock, asynchronous active-low reset
//   start, signed_op    : request a divide (IDLE only), 1 = two's complement DIV
//   cancel              : abort an accepted or in-flight divide
//   a, b                : dividend and divisor, sampled when start is accepted
//   quotient, remainder : result, held until the next completed divide
//   busy                : combinational stall request, done : one-cycle completion pulse
module seq_div_unit
  import seq_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  divState_t        state, nextState;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] remReg, quoReg, divisor, stepRem, stepQuo;
  logic             signQ, signR, accept, lastIter, negA, negB;
  assign negA     = signed_op & a[WIDTH-1];
  assign negB     = signed_op & b[WIDTH-1];
  assign lastIter = counter == CW'(WIDTH - 1);
  seq_div_unit_div_step #(.WIDTH(WIDTH)) step (
    .rem    (remReg),
    .quo    (quoReg),
    .divisor(divisor),
    .nextRem(stepRem),
    .nextQuo(stepQuo)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= DIV_IDLE;
    else      state <= nextState;
  always_comb begin
    nextState = DIV_IDLE;
    accept    = state == DIV_IDLE && start && !cancel;
    case (state)
      DIV_IDLE: nextState = accept ? DIV_CALC : DIV_IDLE;
      DIV_CALC: nextState = cancel ? DIV_IDLE : (lastIter ? DIV_DONE : DIV_CALC);
      default:  nextState = DIV_IDLE;
    endcase
    // busy is gated by rst so the stall drops the instant reset asserts
    busy = rst && (accept || state == DIV_CALC);
    done = state == DIV_DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter   <= '0;
      remReg    <= '0;
      quoReg    <= '0;
      divisor   <= '0;
      signQ     <= 1'b0;
      signR     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      signQ   <= negA ^ negB;
      signR   <= negA;
      quoReg  <= negA ? -a : a;
      divisor <= negB ? -b : b;
      remReg  <= '0;
      counter <= '0;
    end else if (state == DIV_CALC && !cancel) begin
      remReg  <= stepRem;
      quoReg  <= stepQuo;
      counter <= counter + 1'b1;
      // results land on the edge into DONE so they are valid while done is high
      if (lastIter) begin
        quotient  <= signQ ? -stepQuo : stepQuo;
        remainder <= signR ? -stepRem : stepRem;
      end
    end
  end
endmodule

// File: tb/tb_seq_div_unit.sv
// tb_seq_div_unit: randomized and directed checks of seq_div_unit against an arithmetic reference
module tb_seq_div_unit;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, signed_op = 1'b0, cancel = 1'b0;
  logic [31:0] a = '0, b = '0, quotient, remainder;
  logic        busy, done;
  int          nTests = 0, nFail = 0;
  logic [31:0] lastQ = '0, lastR = '0;

  seq_div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signed_op(signed_op),
    .cancel   (cancel),
    .a        (a),
    .b        (b),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] refDiv(input logic [31:0] x, input logic [31:0] y, input bit s);
    logic [31:0] mx, my, q, r;
    if (y == 0) begin
      q = (s && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = x;
    end else if (!s) begin
      q = x / y;
      r = x % y;
    end else begin
      mx = x[31] ? -x : x;
      my = y[31] ? -y : y;
      q = mx / my;
      r = mx % my;
      if (x[31] ^ y[31]) q = -q;
      if (x[31]) r = -r;
    end
    return {q, r};
  endfunction

  task automatic startOp(input string tag, input logic [31:0] x, input logic [31:0] y, input bit s);
    @(negedge clk);
    a = x; b = y; signed_op = s; start = 1'b1; cancel = 1'b0;
    #1 chk({tag, "_busy_c0"}, busy, 1);
  endtask

  task automatic waitDone(input string tag, input logic [31:0] eq, input logic [31:0] er, input bit keep);
    int n = 0;
    bit busyOk = 1;
    do begin
      @(negedge clk);
      n++;
      if (!done && !busy) busyOk = 0;
      if (!keep) start = 1'b0;
    end while (!done && n < 60);
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_busy_calc"}, busyOk, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    lastQ = eq;
    lastR = er;
  endtask

  task automatic runDiv(input string tag, input logic [31:0] x, input logic [31:0] y, input bit s);
    logic [63:0] e;
    e = refDiv(x, y, s);
    startOp(tag, x, y, s);
    waitDone(tag, e[63:32], e[31:0], 0);
  endtask

  initial begin
    logic [63:0] e1, e2;
    logic [31:0] x, y;
    int n;
    bit sawDone;
    start = 1'b1;
    a = 32'd100; b = 32'd7;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst = 1'b1;

    runDiv("divu_100_7", 32'd100, 32'd7, 0);
    runDiv("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1);
    runDiv("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1);
    runDiv("divu_by0", 32'd5, 32'd0, 0);
    runDiv("div_neg_by0", 32'hFFFF_FFF0, 32'd0, 1);
    runDiv("div_pos_by0", 32'd9, 32'd0, 1);
    runDiv("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1);
    runDiv("divu_big", 32'hFFFF_FFFF, 32'd1, 0);

    for (int i = 0; i < 50; i++) begin
      int sel;
      sel = $urandom_range(0, 7);
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      y = (sel == 0) ? 32'd0 :
          (sel == 1) ? 32'($urandom_range(1, 15)) :
          (sel == 2) ? -32'($urandom_range(1, 15)) :
          (sel == 3) ? 32'hFFFF_FFFF : $urandom;
      runDiv("rand", x, y, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    start = 1'b1; cancel = 1'b1;
    #1 chk("idle_cancel_busy", busy, 0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1 chk("idle_cancel_not_taken", busy, 0);

    startOp("cancel", 32'd1000, 32'd3, 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 10) cancel = 1'b1;
    end
    @(negedge clk);
    cancel = 1'b0;
    #1;
    chk("cancel_busy_c11", busy, 0);
    chk("cancel_done_c11", done, 0);
    chk("cancel_q_kept", quotient, lastQ);
    chk("cancel_r_kept", remainder, lastR);
    runDiv("after_cancel", 32'd1000, 32'd3, 0);

    startOp("rst_mid", 32'd12345, 32'd10, 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i < 20) start = 1'b0;
    end
    start = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_q", quotient, 0);
    chk("rst_mid_r", remainder, 0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    sawDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) sawDone = 1;
    end
    chk("rst_mid_discarded", sawDone, 0);

    e1 = refDiv(32'd100, 32'd7, 0);
    e2 = refDiv(32'hFFFF_FF00, 32'd7, 1);
    startOp("b2b", 32'd100, 32'd7, 0);
    @(negedge clk);
    a = 32'hFFFF_FF00; b = 32'd7; signed_op = 1'b1;
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency1", n, 33);
    chk("b2b_busy_done", busy, 0);
    chk("b2b_q1", quotient, e1[63:32]);
    chk("b2b_r1", remainder, e1[31:0]);
    @(negedge clk);
    #1;
    chk("b2b_busy_c34", busy, 1);
    chk("b2b_q1_held_c34", quotient, e1[63:32]);
    chk("b2b_r1_held_c34", remainder, e1[31:0]);
    waitDone("b2b_second", e2[63:32], e2[31:0], 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
